eoc_readout_scheduler: RTL and testbench

- Periphery readout scheduler above a row of congestion-relief arbiters; each arbiter presents one 27-bit word (26-bit pixel data plus side bit) per column group.
- Shares a single readout path among NUM_GRP groups using round-robin grants, which drive each group's shake_hands_col.
- Tags each granted word with group index and time stamp, buffers it in a small FIFO and offers it to the downstream serializer with a valid/ready handshake.

---
 rtl/eoc_readout_scheduler.sv | 119 +++++++++++
 tb/tb_eoc_readout_scheduler.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/eoc_readout_scheduler.sv
// eoc_readout_scheduler: round-robin readout of NUM_GRP column-group words into a tagged show-ahead FIFO
// Ports: clk_40MHz/rst_n (async active-low) clock and reset; readout_en enables granting (low = drain);
// TimeStamp is tagged onto each granted word; data_grp holds the packed group words (nonzero = request);
// shake_hands_col is the one-hot grant; dout/dout_valid/dout_ready form the FIFO head handshake;
// fifo_level is the occupancy; busy is high outside IDLE.
// Build option: define SCHED_STALL_CNT_EN to add stall_cnt, counting RUN cycles blocked by a full FIFO.
module eoc_readout_scheduler #(
    parameter int NUM_GRP    = 8,
    parameter int GRP_AW     = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic                    clk_40MHz,
    input  logic                    rst_n,
    input  logic                    readout_en,
    input  logic [8:0]              TimeStamp,
    input  logic [NUM_GRP*27-1:0]   data_grp,
    output logic [NUM_GRP-1:0]      shake_hands_col,
    output logic [GRP_AW+35:0]      dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic [FIFO_AW:0]        fifo_level,
    output logic                    busy
`ifdef SCHED_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, next_state;
    logic [NUM_GRP-1:0] req;
    logic [GRP_AW-1:0] rr_ptr, gnt_idx, idx;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr, prev_ptr;
    logic [GRP_AW+35:0] mem [FIFO_DEPTH];
    logic full, grant_en, found, wr, rd;

    assign full       = fifo_level == (FIFO_AW+1)'(FIFO_DEPTH);
    assign dout_valid = fifo_level != '0;
    assign wr         = found;
    assign rd         = dout_valid & dout_ready;
    assign prev_ptr   = rd_ptr - FIFO_AW'(1);
    // When empty the slot just behind rd_ptr holds the last entry read, so dout keeps showing it.
    assign dout       = dout_valid ? mem[rd_ptr] : mem[prev_ptr];

    always_comb begin
        for (int i = 0; i < NUM_GRP; i++)
            req[i] = |data_grp[27*i +: 27];
    end

    always_ff @(posedge clk_40MHz or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = readout_en ? RUN : IDLE;
            RUN:     next_state = readout_en ? RUN : DRAIN;
            default: next_state = readout_en ? RUN : (dout_valid ? DRAIN : IDLE);
        endcase
    end

    // readout_en gates the grant directly so a falling enable withdraws it within the cycle.
    always_comb begin
        busy     = state != IDLE;
        grant_en = (state == RUN) && readout_en && !full;
    end

    // Round-robin search starting at rr_ptr; the GRP_AW-bit sum wraps NUM_GRP-1 -> 0.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 0; k < NUM_GRP; k++) begin
            idx = rr_ptr + GRP_AW'(k);
            if (grant_en && !found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        shake_hands_col = found ? (NUM_GRP'(1) << gnt_idx) : '0;
    end

    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= {gnt_idx, TimeStamp, data_grp[27*gnt_idx +: 27]};
                wr_ptr      <= wr_ptr + FIFO_AW'(1);
                rr_ptr      <= gnt_idx + GRP_AW'(1);
            end
            if (rd)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            fifo_level <= fifo_level + (FIFO_AW+1)'(wr) - (FIFO_AW+1)'(rd);
        end
    end

`ifdef SCHED_STALL_CNT_EN
    logic en_q;
    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            stall_cnt <= '0;
        end else begin
            en_q <= readout_en;
            if (readout_en && !en_q)
                stall_cnt <= '0;
            else if (state == RUN && |req && full && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_eoc_readout_scheduler.sv
// tb_eoc_readout_scheduler: directed self-checking bench for eoc_readout_scheduler
module tb_eoc_readout_scheduler;
    logic         clk_40MHz = 1'b0;
    logic         rst_n, readout_en, dout_ready;
    logic [8:0]   TimeStamp;
    logic [215:0] data_grp;
    logic [7:0]   shake_hands_col;
    logic [38:0]  dout;
    logic         dout_valid, busy;
    logic [3:0]   fifo_level;
`ifdef SCHED_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif
    int n_chk = 0;
    int n_fail = 0;

    eoc_readout_scheduler dut (
        .clk_40MHz(clk_40MHz), .rst_n(rst_n), .readout_en(readout_en), .TimeStamp(TimeStamp),
        .data_grp(data_grp), .shake_hands_col(shake_hands_col), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .fifo_level(fifo_level), .busy(busy)
`ifdef SCHED_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk_40MHz = ~clk_40MHz;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setw(input int g, input logic [26:0] w);
        data_grp[27*g +: 27] = w;
    endtask

    function automatic logic [38:0] ent(input int g, input int ts, input logic [26:0] w);
        return {3'(g), 9'(ts), w};
    endfunction

    function automatic logic [26:0] wk(input int k);
        return 27'h1000 + 27'(k);
    endfunction

    initial begin
        rst_n = 1'b0; readout_en = 1'b0; dout_ready = 1'b0; TimeStamp = '0; data_grp = '0;
        #1;
        chk("rst_grant", shake_hands_col, 0);
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
`ifdef SCHED_STALL_CNT_EN
        chk("rst_stall", stall_cnt, 0);
`endif
        @(negedge clk_40MHz); rst_n = 1'b1; readout_en = 1'b1; dout_ready = 1'b1;
        repeat (3) begin
            @(negedge clk_40MHz); #1;
            chk("zero_grant", shake_hands_col, 0);
            chk("zero_valid", dout_valid, 0);
            chk("zero_busy", busy, 1);
        end
        // groups 2 and 5, pointer starting at 0
        setw(2, 27'h0000123); setw(5, 27'h7FFFFFF); TimeStamp = 9'd10; #1;
        chk("g25_grant0", shake_hands_col, 8'h04);
        @(negedge clk_40MHz); setw(2, 27'h0000456); TimeStamp = 9'd11; #1;
        chk("g25_grant1", shake_hands_col, 8'h20);
        chk("g25_dout0", dout, ent(2, 10, 27'h0000123));
        chk("g25_valid0", dout_valid, 1);
        @(negedge clk_40MHz); setw(5, 27'h4000000); TimeStamp = 9'd12; #1;
        chk("g25_grant2", shake_hands_col, 8'h04);
        chk("g25_dout1", dout, ent(5, 11, 27'h7FFFFFF));
        @(negedge clk_40MHz); setw(2, 27'h0); TimeStamp = 9'd13; #1;
        chk("g25_grant3", shake_hands_col, 8'h20);
        chk("g25_dout2", dout, ent(2, 12, 27'h0000456));
        @(negedge clk_40MHz); setw(5, 27'h0); #1;
        chk("g25_grant_end", shake_hands_col, 0);
        chk("g25_dout3", dout, ent(5, 13, 27'h4000000));
        chk("g25_level", fifo_level, 1);
        @(negedge clk_40MHz); #1;
        chk("g25_empty_valid", dout_valid, 0);
        chk("g25_dout_hold", dout, ent(5, 13, 27'h4000000));
        // wrap: pointer at 6, groups 1 and 7
        setw(1, 27'h0000001); setw(7, 27'h5555555); TimeStamp = 9'd20; #1;
        chk("wrap_grant0", shake_hands_col, 8'h80);
        @(negedge clk_40MHz); setw(7, 27'h0); TimeStamp = 9'd21; #1;
        chk("wrap_grant1", shake_hands_col, 8'h02);
        chk("wrap_dout0", dout, ent(7, 20, 27'h5555555));
        @(negedge clk_40MHz); setw(1, 27'h0); #1;
        chk("wrap_dout1", dout, ent(1, 21, 27'h0000001));
        chk("wrap_grant_end", shake_hands_col, 0);
        @(negedge clk_40MHz); #1;
        chk("wrap_level", fifo_level, 0);
        // constant word re-granted, then drain
        dout_ready = 1'b0; setw(3, 27'h2AAAAAA); TimeStamp = 9'd30; #1;
        chk("dr_grant0", shake_hands_col, 8'h08);
        @(negedge clk_40MHz); TimeStamp = 9'd31; #1;
        chk("dr_grant1", shake_hands_col, 8'h08);
        chk("dr_level1", fifo_level, 1);
        @(negedge clk_40MHz); TimeStamp = 9'd32; #1;
        chk("dr_grant2", shake_hands_col, 8'h08);
        @(negedge clk_40MHz); readout_en = 1'b0; #1;
        chk("en_fall_grant", shake_hands_col, 0);
        chk("dr_level3", fifo_level, 3);
        @(negedge clk_40MHz); #1;
        chk("drain_level", fifo_level, 3);
        chk("drain_busy", busy, 1);
        chk("drain_grant", shake_hands_col, 0);
        dout_ready = 1'b1;
        chk("drain_dout0", dout, ent(3, 30, 27'h2AAAAAA));
        @(negedge clk_40MHz); #1;
        chk("drain_dout1", dout, ent(3, 31, 27'h2AAAAAA));
        @(negedge clk_40MHz); #1;
        chk("drain_dout2", dout, ent(3, 32, 27'h2AAAAAA));
        @(negedge clk_40MHz); #1;
        chk("drain_empty_level", fifo_level, 0);
        chk("drain_empty_valid", dout_valid, 0);
        chk("drain_busy_last", busy, 1);
        @(negedge clk_40MHz); #1;
        chk("idle_busy", busy, 0);
        setw(3, 27'h0);
        // all groups requesting, full FIFO behaviour, from a fresh reset
        rst_n = 1'b0; readout_en = 1'b1; dout_ready = 1'b0;
        for (int k = 0; k < 8; k++) setw(k, wk(k));
        @(negedge clk_40MHz); rst_n = 1'b1;
        @(negedge clk_40MHz);
        for (int k = 0; k < 8; k++) begin
            TimeStamp = 9'(100 + k); #1;
            chk("all_grant", shake_hands_col, 64'(8'(1) << k));
            @(negedge clk_40MHz);
        end
        #1;
        chk("full_level", fifo_level, 8);
        chk("full_grant", shake_hands_col, 0);
        chk("full_dout", dout, ent(0, 100, wk(0)));
        @(negedge clk_40MHz); dout_ready = 1'b1; #1;
        chk("full_rd_grant", shake_hands_col, 0);
        @(negedge clk_40MHz); dout_ready = 1'b0; TimeStamp = 9'd108; #1;
        chk("after_rd_level", fifo_level, 7);
        chk("after_rd_dout", dout, ent(1, 101, wk(1)));
        chk("after_rd_grant", shake_hands_col, 8'h01);
        @(negedge clk_40MHz); #1;
        chk("refill_level", fifo_level, 8);
`ifdef SCHED_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 2);
`endif
        // async reset with five entries held
        data_grp = '0; dout_ready = 1'b1;
        repeat (3) @(negedge clk_40MHz);
        #1;
        chk("five_level", fifo_level, 5);
        dout_ready = 1'b0;
        for (int k = 0; k < 8; k++) setw(k, wk(k));
        #1;
        chk("pre_rst_grant", shake_hands_col, 8'h02);
        #1; rst_n = 1'b0; #1;
        chk("async_valid", dout_valid, 0);
        chk("async_level", fifo_level, 0);
        chk("async_grant", shake_hands_col, 0);
        chk("async_busy", busy, 0);
        chk("async_dout", dout, 0);
        @(negedge clk_40MHz); rst_n = 1'b1; #1;
        chk("post_rst_grant", shake_hands_col, 0);
`ifdef SCHED_STALL_CNT_EN
        chk("post_rst_stall", stall_cnt, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
